// File: rtl/selector_pkg.sv
// Shared constants and state encodings for stream_selector.
// The lock encoding is only used when SEL_LAST_LOCK_EN is defined.
package selector_pkg;

  localparam logic SEL_MODE_FIXED = 1'b0;
  localparam logic SEL_MODE_RR    = 1'b1;

  // Output register occupancy
  typedef enum logic {
    OutEmpty,
    OutFull
  } out_state_e;

  // Packet lock state
  typedef enum logic {
    LockIdle,
    LockLocked
  } lock_state_e;

endpackage

// File: rtl/stream_selector_if.sv
// Handshake and data bundle between the N_CH sources, the selector and the single sink.
// in_last/out_last exist only when SEL_LAST_LOCK_EN is defined.
interface stream_selector_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_CH  = 4
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [N_CH*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
`ifdef SEL_LAST_LOCK_EN
  logic [N_CH-1:0]       in_last;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid channel at or after ptr, wrapping.
// Produces a one-hot grant and its index; grant is all-zero when no channel is valid.
module rr_arbiter #(
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  in_valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_selector.sv
// N-channel registered stream selector with fixed or round-robin source selection.
// Define SEL_LAST_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_selector
  import selector_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  stream_selector_if.slave   bus
);

  out_state_e        out_state_q, out_state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
`ifdef SEL_LAST_LOCK_EN
  lock_state_e       lock_q, lock_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic              out_last_q, out_last_d;
  logic              sel_last;
`endif

  logic [N_CH-1:0]   arb_grant;
  logic [SEL_W-1:0]  arb_idx;
  logic [N_CH-1:0]   fixed_oh;
  logic [N_CH-1:0]   grant_oh;
  logic [SEL_W-1:0]  grant_idx;
  logic              load;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr_arbiter (
    .in_valid  (bus.in_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Grant selection and input handshake
  always_comb begin
    fixed_oh = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) fixed_oh[k] = 1'b1;
    end

    if (mode == SEL_MODE_RR) begin
      grant_oh  = arb_grant;
      grant_idx = arb_idx;
    end else begin
      grant_oh  = fixed_oh;
      grant_idx = sel;
    end

`ifdef SEL_LAST_LOCK_EN
    if (lock_q == LockLocked) begin
      grant_oh            = '0;
      grant_oh[lock_ch_q] = 1'b1;
      grant_idx           = lock_ch_q;
    end
`endif

    load         = (out_state_q == OutEmpty) || bus.out_ready;
    bus.in_ready = load ? grant_oh : '0;
    xfer         = |(bus.in_ready & bus.in_valid);

    sel_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant_oh[k]) sel_data = bus.in_data[k*WIDTH +: WIDTH];
    end
`ifdef SEL_LAST_LOCK_EN
    sel_last = |(bus.in_last & grant_oh);
`endif
  end

  // Next-state: output register, rr pointer, packet lock
  always_comb begin
    out_state_d = out_state_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
`ifdef SEL_LAST_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif

    if (xfer) begin
      out_state_d = OutFull;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      if (mode == SEL_MODE_RR) begin
        ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
`ifdef SEL_LAST_LOCK_EN
      out_last_d = sel_last;
      unique case (lock_q)
        LockIdle: begin
          if (!sel_last) begin
            lock_d    = LockLocked;
            lock_ch_d = grant_idx;
          end
        end
        LockLocked: begin
          if (sel_last) lock_d = LockIdle;
        end
        default: lock_d = LockIdle;
      endcase
`endif
    end else if (bus.out_ready) begin
      out_state_d = OutEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q <= OutEmpty;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
`ifdef SEL_LAST_LOCK_EN
      lock_q      <= LockIdle;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_state_q <= out_state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
`ifdef SEL_LAST_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = (out_state_q == OutFull);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
`ifdef SEL_LAST_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.in_ready));

  // A stalled beat must not change under the sink
  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_ch)));

endmodule
